// File: rtl/cpu7_icu_fetch_resp_pkg.sv
// Shared types and constants for the ICU fetch responder: FSM encoding,
// fixed bus widths and doubleword alignment helper.
package cpu7_icu_fetch_resp_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int OFF_W  = 3;
  localparam logic [OFF_W-1:0] ALIGN_PAD = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] dw_addr(input logic [ADDR_W-OFF_W-1:0] line);
    return {line, ALIGN_PAD};
  endfunction

endpackage

// File: rtl/cpu7_icu_fetch_resp.sv
// ICU-side fetch responder: one outstanding 8-byte read per IFU request,
// with cancel/replacement handling that drains the in-flight response.
module cpu7_icu_fetch_resp
  import cpu7_icu_fetch_resp_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              ifu_icu_req_ic1,
  input  logic [ADDR_W-1:0] ifu_icu_addr_ic1,
  output logic              icu_ifu_ack_ic1,
  input  logic              ifu_icu_cancel,
  output logic [DATA_W-1:0] icu_ifu_data_ic2,
  output logic              icu_ifu_data_valid_ic2,
  output logic              icu_mem_req,
  output logic [ADDR_W-1:0] icu_mem_addr,
  input  logic              mem_icu_gnt,
  input  logic              mem_icu_rvalid,
  input  logic [DATA_W-1:0] mem_icu_rdata
);

  fetch_state_e state_q, state_d;
  logic kill_q, kill_d;
  logic pend_q, pend_d;
  logic [ADDR_W-OFF_W-1:0] addr_q, pend_addr_q, addr_nxt;
  logic addr_ld, addr_from_pend, pend_ld;
  logic idle, ack, rsp, deliver;
  logic unused_addr_bits;

  assign unused_addr_bits = ^ifu_icu_addr_ic1[OFF_W-1:0];

  assign idle    = (state_q == ST_IDLE);
  assign ack     = resetn & ifu_icu_req_ic1 & (idle | ifu_icu_cancel);
  assign rsp     = (state_q == ST_WAIT) & mem_icu_rvalid;
  assign deliver = rsp & ~kill_q & ~ifu_icu_cancel;
  assign pend_ld = ack & ~idle;

  // A replacement that arrives in the same cycle as the drained response
  // bypasses the pending register and is issued directly.
  assign addr_nxt = !addr_from_pend ? ifu_icu_addr_ic1[ADDR_W-1:OFF_W]
                  : (ack ? ifu_icu_addr_ic1[ADDR_W-1:OFF_W] : pend_addr_q);

  always_comb begin
    state_d        = state_q;
    kill_d         = kill_q;
    pend_d         = pend_q;
    addr_ld        = 1'b0;
    addr_from_pend = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ack) begin
          state_d = ST_REQ;
          addr_ld = 1'b1;
          kill_d  = 1'b0;
        end
      end
      ST_REQ: begin
        if (ifu_icu_cancel) kill_d = 1'b1;
        if (ack)            pend_d = 1'b1;
        if (mem_icu_gnt)    state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_icu_rvalid) begin
          kill_d = 1'b0;
          if (deliver) begin
            state_d = ST_IDLE;
          end else if (pend_q | ack) begin
            state_d        = ST_REQ;
            addr_ld        = 1'b1;
            addr_from_pend = 1'b1;
            pend_d         = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (ifu_icu_cancel) kill_d = 1'b1;
          if (ack)            pend_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (addr_ld) addr_q <= addr_nxt;
    if (pend_ld) pend_addr_q <= ifu_icu_addr_ic1[ADDR_W-1:OFF_W];
  end

  assign icu_ifu_ack_ic1        = ack;
  assign icu_ifu_data_valid_ic2 = resetn & deliver;
  assign icu_ifu_data_ic2       = icu_ifu_data_valid_ic2 ? mem_icu_rdata : '0;
  assign icu_mem_req            = resetn & (state_q == ST_REQ);
  assign icu_mem_addr           = icu_mem_req ? dw_addr(addr_q) : '0;

endmodule

// File: tb/tb_cpu7_icu_fetch_resp.sv
// Bench for cpu7_icu_fetch_resp: directed protocol scenarios followed by
// randomized traffic, checked against a fetch-transaction reference model.
module tb_cpu7_icu_fetch_resp;

  logic        clk = 1'b0;
  logic        resetn, req, cancel, gnt, rvalid;
  logic [31:0] addr;
  logic [63:0] rdata;
  logic        ack, dv, mreq;
  logic [63:0] data;
  logic [31:0] maddr;

  cpu7_icu_fetch_resp dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .ifu_icu_req_ic1        (req),
    .ifu_icu_addr_ic1       (addr),
    .icu_ifu_ack_ic1        (ack),
    .ifu_icu_cancel         (cancel),
    .icu_ifu_data_ic2       (data),
    .icu_ifu_data_valid_ic2 (dv),
    .icu_mem_req            (mreq),
    .icu_mem_addr           (maddr),
    .mem_icu_gnt            (gnt),
    .mem_icu_rvalid         (rvalid),
    .mem_icu_rdata          (rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned strobes  = 0;

  // Reference model: the fetch being served, whether it was cancelled, the
  // queued replacement, and the memory transaction state.
  logic        cur_valid = 1'b0, killed = 1'b0, pend_valid = 1'b0, granted = 1'b0;
  logic [31:0] cur_addr = '0, pend_addr = '0, gaddr = '0;
  int          delay = 0;

  logic        o_ack, o_dv, o_mreq;
  logic [63:0] o_data;
  logic [31:0] o_maddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rn, input logic rq, input logic [31:0] a, input logic cn,
                     input logic g, input logic rv, input logic [63:0] rd);
    logic        e_ack, e_dv, e_mreq;
    logic [63:0] e_data;
    logic [31:0] e_maddr;
    resetn = rn; req = rq; addr = a; cancel = cn; gnt = g; rvalid = rv; rdata = rd;
    #1;
    e_ack   = rn && rq && (!cur_valid || cn);
    e_mreq  = rn && cur_valid && !granted;
    e_maddr = e_mreq ? {cur_addr[31:3], 3'b000} : 32'h0;
    e_dv    = rn && granted && rv && !killed && !cn;
    e_data  = e_dv ? rd : 64'h0;
    o_ack = ack; o_dv = dv; o_data = data; o_mreq = mreq; o_maddr = maddr;
    chk("ack", o_ack, e_ack);
    chk("data_valid", o_dv, e_dv);
    chk("data", o_data, e_data);
    chk("mem_req", o_mreq, e_mreq);
    chk("mem_addr", o_maddr, e_maddr);
    if (o_dv) strobes++;
    if (!rn) begin
      cur_valid = 0; killed = 0; pend_valid = 0; granted = 0;
    end else if (granted && rv) begin
      granted = 0;
      if (e_dv) begin
        cur_valid = 0;
      end else begin
        if (e_ack) begin pend_valid = 1; pend_addr = a; end
        if (pend_valid) begin cur_addr = pend_addr; pend_valid = 0; end
        else cur_valid = 0;
        killed = 0;
      end
    end else begin
      if (cn && cur_valid) killed = 1;
      if (e_ack) begin
        if (cur_valid) begin pend_valid = 1; pend_addr = a; end
        else begin cur_valid = 1; cur_addr = a; killed = 0; end
      end
      if (e_mreq && g) begin
        granted = 1;
        gaddr   = {cur_addr[31:3], 3'b000};
        delay   = $urandom_range(0, 2);
      end else if (granted) begin
        delay--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned s0;
    logic rq, cn, g, rv, rn;
    logic [31:0] a;
    logic [63:0] rd;
    resetn = 0; req = 0; addr = '0; cancel = 0; gnt = 0; rvalid = 0; rdata = '0;
    @(posedge clk);
    #1;

    // Reset: everything quiet, even with stray inputs active
    cyc(0, 1, 32'h1c000004, 0, 1, 1, 64'hdead);
    chk("rst_ack", o_ack, 0);
    chk("rst_mreq", o_mreq, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Basic fetch
    cyc(1, 1, 32'h1c000004, 0, 0, 0, 0);
    chk("basic_ack", o_ack, 1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("basic_maddr", o_maddr, 32'h1c000000);
    cyc(1, 0, 0, 0, 0, 1, 64'h0000_0001_0000_0002);
    chk("basic_dv", o_dv, 1);
    chk("basic_data", o_data, 64'h0000_0001_0000_0002);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("basic_idle_dv", o_dv, 0);

    // Grant back-pressure: request held stable four cycles
    cyc(1, 1, 32'h1c00000f, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("bp_maddr", o_maddr, 32'h1c000008);
    end
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("bp_mreq", o_mreq, 1);
    cyc(1, 0, 0, 0, 0, 1, 64'h1122334455667788);
    chk("bp_dv", o_dv, 1);

    // Cancel + refetch while waiting for data
    s0 = strobes;
    cyc(1, 1, 32'h1c000000, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 32'h1c000100, 1, 0, 0, 0);
    chk("cx_ack", o_ack, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 64'hbad0bad0bad0bad0);
    chk("cx_drop_dv", o_dv, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("cx_maddr", o_maddr, 32'h1c000100);
    cyc(1, 0, 0, 0, 0, 1, 64'h0123456789abcdef);
    chk("cx_dv", o_dv, 1);
    chk("cx_strobes", 64'(strobes - s0), 1);

    // Cancel in the same cycle as rvalid, no replacement
    cyc(1, 1, 32'h1c000040, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 1, 64'h5555aaaa5555aaaa);
    chk("sc_dv", o_dv, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("sc_mreq", o_mreq, 0);
    cyc(1, 1, 32'h1c000048, 0, 0, 0, 0);
    chk("sc_idle_ack", o_ack, 1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 64'h48);

    // Double cancel during drain: only the newest replacement is fetched
    s0 = strobes;
    cyc(1, 1, 32'h1c000200, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 32'h1c000300, 1, 0, 0, 0);
    cyc(1, 1, 32'h1c000400, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 64'h200);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("dbl_maddr", o_maddr, 32'h1c000400);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 64'h400);
    chk("dbl_data", o_data, 64'h400);
    chk("dbl_strobes", 64'(strobes - s0), 1);

    // Reset while waiting; the late response must vanish
    cyc(1, 1, 32'h1c000500, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rw_mreq", o_mreq, 0);
    cyc(1, 0, 0, 0, 0, 1, 64'h500);
    chk("rw_dv", o_dv, 0);
    cyc(1, 1, 32'h1c000600, 0, 0, 0, 0);
    chk("rw_ack", o_ack, 1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 64'h600);
    chk("rw_dv2", o_dv, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 199) != 0);
      a  = $urandom;
      rq = 0; cn = 0;
      if (!cur_valid) rq = $urandom_range(0, 1);
      else if ($urandom_range(0, 7) == 0) begin cn = 1; rq = $urandom_range(0, 1); end
      g  = (cur_valid && !granted) ? ($urandom_range(0, 2) != 0) : 1'b0;
      if (granted) begin
        rv = (delay <= 0);
        rd = {~gaddr, gaddr};
      end else begin
        rv = ($urandom_range(0, 7) == 0);
        rd = {$urandom, $urandom};
      end
      cyc(rn, rq, a, cn, g, rv, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
